popcnt_arbiter: RTL
===================

# popcnt_arbiter

Round-robin arbiter and sequencer that shares one bit-count (popcount) unit between REQ_NUM requesters. It accepts words through per-requester valid/ready handshakes and launches them into the unit's data_val/data interface. It tags every launch with the requester ID and routes each returned count back with that ID. It sits between the client blocks and the single popcount instance, whose in-order, no-backpressure behaviour it relies on.

## Interface
- WIDTH, 8: data word width; count width CNT_W = $clog2(WIDTH)+1.
- REQ_NUM, 4: number of requesters, ≥2; ID width ID_W = $clog2(REQ_NUM).
- MAX_INFLIGHT, 4: maximum launched-but-unreturned words, power of 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- srst_i  in  1  synchronous active-high reset; also drives the popcount unit's srst_i.
- req_val_i  in  REQ_NUM  per-requester data valid.
- req_data_i  in  REQ_NUM×WIDTH  packed [REQ_NUM-1:0][WIDTH-1:0] request words.
- req_ready_o  out  REQ_NUM  one-hot grant; a word transfers when val&ready.
- pc_data_val_o  out  1  to the unit's data_val_i.
- pc_data_o  out  WIDTH  to the unit's data_i.
- pc_data_val_i  in  1  from the unit's data_val_o.
- pc_data_i  in  CNT_W  from the unit's data_o.
- res_val_o  out  1  result valid, one cycle per result.
- res_id_o  out  ID_W  requester that owns the result.
- res_data_o  out  CNT_W  popcount of that requester's word.
- busy_o  out  1  inflight count ≠ 0.
- err_o  out  1  sticky: a result arrived with no outstanding tag.

## Operation
- Arbitration is combinational each cycle: among set req_val_i bits, pick the first index after last_grant, cyclically. Example: with last_grant=1 and requests {0,3}, pick 3.
- A grant is allowed when the tag FIFO is not full, or when it is full and pc_data_val_i=1 in the same cycle (simultaneous pop and push).
- req_ready_o has only the granted bit set, and only if grant is allowed. It may depend combinationally on req_val_i. A requester holds val and data stable until ready.
- On grant, at the clock edge:
  - pc_data_val_o is set to 1.
  - pc_data_o is loaded with the granted word.
  - The ID is pushed to the tag FIFO.
  - last_grant is loaded with the granted ID.
- With no grant, pc_data_val_o is 0, pc_data_o holds its value, and last_grant is unchanged.
- On pc_data_val_i with FIFO non-empty: pop the tag. Next cycle, res_val_o=1, res_id_o=tag, res_data_o=pc_data_i.
- On pc_data_val_i with FIFO empty: set err_o=1 (sticky until srst_i), drop the result, and leave res_val_o at 0.
- Inflight count = FIFO occupancy, range 0..MAX_INFLIGHT. It is unchanged on a simultaneous push and pop.
- Reset (including mid-operation) drops every inflight tag. The popcount unit is reset by the same srst_i, so no stale results return.

## Timing
- Reset values: req_ready_o=0, pc_data_val_o=0, pc_data_o=0, res_val_o=0, res_id_o=0, res_data_o=0, busy_o=0, err_o=0, last_grant=REQ_NUM-1 (requester 0 wins first).
- Request handshake to pc_data_val_o: 1 cycle. Throughput: 1 launch per cycle.
- pc_data_val_i to res_val_o: 1 cycle.
- End to end: 2 cycles plus the unit's latency.
- busy_o is registered and reflects occupancy after the current edge.
- srst_i wins over every simultaneous event.

## Structure
- Package popcnt_arb_pkg holds:
  - defaults WIDTH_DEF=8, REQ_NUM_DEF=4, MAX_INFLIGHT_DEF=4;
  - functions cnt_w(width) = $clog2(width)+1 and id_w(n) = $clog2(n).
- ID_W, CNT_W and the req_id_t typedef are localparams/typedefs inside the module, derived from the package functions.
- Sub-module popcnt_tag_fifo is a synchronous FIFO of ID_W-bit tags, depth MAX_INFLIGHT. It has push, pop, full, empty and a usage count, and supports simultaneous push and pop when full.

## Test plan
- Requester 0 sends 8'hFF, unit model latency 1 → pc_data_val_o with 8'hFF one cycle later; res_val_o with id 0, data 8 two cycles after that. Repeat with 8'hA5 → 4 and 8'h00 → 0.
- All 4 requesters valid continuously from reset → grant order 0,1,2,3,0,1…, exactly one ready bit per cycle. Every result ID matches its word's popcount against a reference queue per requester.
- Only requesters 1 and 3 valid, last_grant=1 → grants 3,1,3,1; bits 0 and 2 never ready.
- Unit model latency 10, all valid → 4 grants, then ready stays 0 and busy_o=1. In the cycle the first result returns, one grant occurs and occupancy stays 4.
- pc_data_val_i pulsed with FIFO empty → err_o=1 next cycle and held, res_val_o stays 0. err_o clears only on srst_i.
- srst_i asserted with 3 words inflight → next cycle all outputs 0 and busy_o=0. The first post-reset grant goes to requester 0, and no stale res_val_o appears.

Source files
------------

// File: rtl/popcnt_arb_pkg.sv
// Shared defaults and width helpers for the popcount arbiter slice.
package popcnt_arb_pkg;

   localparam int unsigned WIDTH_DEF        = 8;
   localparam int unsigned REQ_NUM_DEF      = 4;
   localparam int unsigned MAX_INFLIGHT_DEF = 4;

   function automatic int unsigned cnt_w(input int unsigned width);
      return 32'($clog2(width)) + 32'd1;
   endfunction

   function automatic int unsigned id_w(input int unsigned n);
      return 32'($clog2(n));
   endfunction

endpackage

// File: rtl/popcnt_tag_fifo.sv
// Requester-ID tag FIFO; records launch order so in-order results can be routed back.
module popcnt_tag_fifo
   import popcnt_arb_pkg::*;
#(
   parameter  int unsigned DATA_W = id_w(REQ_NUM_DEF),
   parameter  int unsigned DEPTH  = MAX_INFLIGHT_DEF,
   localparam int unsigned USE_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data_c,
   output logic              full_c,
   output logic              empty_c,
   output logic [USE_W-1:0]  usage
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage needs no reset: pointers and usage gate every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usage  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      usage <= usage + USE_W'(1);
         else if (pop && !push) usage <= usage - USE_W'(1);
      end
   end

   assign pop_data_c = mem[rd_ptr];
   assign full_c     = (usage == USE_W'(DEPTH));
   assign empty_c    = (usage == '0);

endmodule

// File: rtl/popcnt_arbiter.sv
// Round-robin sharing of one in-order popcount unit among REQ_NUM requesters,
// with ID tagging of every launch and routing of each returned count.
module popcnt_arbiter
   import popcnt_arb_pkg::*;
#(
   parameter  int unsigned WIDTH        = WIDTH_DEF,
   parameter  int unsigned REQ_NUM      = REQ_NUM_DEF,
   parameter  int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   localparam int unsigned CNT_W        = cnt_w(WIDTH),
   localparam int unsigned ID_W         = id_w(REQ_NUM)
) (
   input  logic                            clk_i,
   input  logic                            srst_i,
   input  logic [REQ_NUM-1:0]              req_val_i,
   input  logic [REQ_NUM-1:0][WIDTH-1:0]   req_data_i,
   output logic [REQ_NUM-1:0]              req_ready_o,
   output logic                            pc_data_val_o,
   output logic [WIDTH-1:0]                pc_data_o,
   input  logic                            pc_data_val_i,
   input  logic [CNT_W-1:0]                pc_data_i,
   output logic                            res_val_o,
   output logic [ID_W-1:0]                 res_id_o,
   output logic [CNT_W-1:0]                res_data_o,
   output logic                            busy_o,
   output logic                            err_o
);

   typedef logic [ID_W-1:0] req_id_t;

   localparam int unsigned USE_W = $clog2(MAX_INFLIGHT) + 1;

   req_id_t            last_grant;
   req_id_t            gnt_id;
   req_id_t            tag;
   logic               gnt_found;
   logic               launch;
   logic               pop;
   logic               full;
   logic               empty;
   logic [USE_W-1:0]   usage;
   logic [USE_W-1:0]   usage_nxt;
   logic [REQ_NUM-1:0] low_mask;
   logic [REQ_NUM-1:0] upper_req;
   logic [REQ_NUM-1:0] pick_vec;

   // Requests above last_grant take priority; otherwise wrap to the lowest index.
   always_comb begin
      low_mask  = (REQ_NUM'(2) << last_grant) - REQ_NUM'(1);
      upper_req = req_val_i & ~low_mask;
      pick_vec  = (upper_req != '0) ? upper_req : req_val_i;
      gnt_found = (pick_vec != '0);
      gnt_id    = '0;
      for (int i = int'(REQ_NUM) - 1; i >= 0; i--) begin
         if (pick_vec[ID_W'(i)]) gnt_id = ID_W'(i);
      end
   end

   // A full FIFO can still accept when a result pops in the same cycle.
   always_comb begin
      launch      = gnt_found && (!full || pc_data_val_i) && !srst_i;
      pop         = pc_data_val_i && !empty;
      req_ready_o = launch ? (REQ_NUM'(1) << gnt_id) : '0;
      usage_nxt   = usage + USE_W'(launch) - USE_W'(pop);
   end

   popcnt_tag_fifo #(
      .DATA_W (ID_W),
      .DEPTH  (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk        (clk_i),
      .srst       (srst_i),
      .push       (launch),
      .push_data  (gnt_id),
      .pop        (pop),
      .pop_data_c (tag),
      .full_c     (full),
      .empty_c    (empty),
      .usage      (usage)
   );

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         last_grant    <= ID_W'(REQ_NUM - 1);
         pc_data_val_o <= 1'b0;
         pc_data_o     <= '0;
         res_val_o     <= 1'b0;
         res_id_o      <= '0;
         res_data_o    <= '0;
         busy_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         pc_data_val_o <= launch;
         if (launch) begin
            pc_data_o  <= req_data_i[gnt_id];
            last_grant <= gnt_id;
         end
         res_val_o <= pop;
         if (pop) begin
            res_id_o   <= tag;
            res_data_o <= pc_data_i;
         end
         busy_o <= (usage_nxt != '0);
         // A result with no outstanding tag is dropped and flagged until reset.
         if (pc_data_val_i && empty) err_o <= 1'b1;
      end
   end

endmodule
